// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : cpu_mem_pkg
//  Brief    : Shared state encoding, port ids and default widths for the
//             unified-memory arbiter of the multicycle core.
//  Revision : 1.0
// ============================================================================
package cpu_mem_pkg;

    localparam int unsigned DEFAULT_AW = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-input tie-break; returns the id of the port to grant.
//  Revision : 1.0
// ============================================================================
module rr_arb2
    import cpu_mem_pkg::*;
#(
    parameter int PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt
);

    // req[0] is the fetch port, req[1] the load/store port
    always_comb begin
        gnt = PORT_IF;
        if (req == 2'b11) begin
            gnt = (PRIO != 0) ? PORT_DM : ~last_gnt;
        end else if (req[1]) begin
            gnt = PORT_DM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one single-port memory between the fetch and load/store
//             ports; one transaction in flight, fixed read latency.
//  Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int MEM_LAT = 2,
    parameter int PRIO    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_ack,
    output logic [31:0]   dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam int c_cnt_w = $clog2(MEM_LAT + 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_last_gnt;
    logic               r_gnt;
    logic               w_arb_gnt;
    logic [1:0]         w_req;
    logic               w_any_req;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_we;
    logic [3:0]         r_be;
    logic [AW-1:0]      r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_dm_rdata;
    logic               w_last_beat;

    assign w_req       = {dm_req, if_req};
    assign w_any_req   = |w_req;
    assign w_last_beat = (r_cnt == c_cnt_w'(1));

    rr_arb2 #(
        .PRIO (PRIO)
    ) u_rr_arb2 (
        .req      (w_req),
        .last_gnt (r_last_gnt),
        .gnt      (w_arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_last_beat) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en = (r_state == ST_ISSUE);
        busy   = (r_state != ST_IDLE);
        if_ack = (r_state == ST_DONE) && (r_gnt == PORT_IF);
        dm_ack = (r_state == ST_DONE) && (r_gnt == PORT_DM);
    end

    // Request latch, latency counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= PORT_DM;
            r_gnt      <= PORT_IF;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_be       <= 4'h0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt      <= w_arb_gnt;
                        r_last_gnt <= w_arb_gnt;
                        if (w_arb_gnt == PORT_DM) begin
                            r_we    <= dm_we;
                            r_be    <= dm_be;
                            r_addr  <= dm_addr;
                            r_wdata <= dm_wdata;
                        end else begin
                            r_we    <= 1'b0;
                            r_be    <= 4'hF;
                            r_addr  <= if_addr;
                        end
                    end
                end
                ST_ISSUE: r_cnt <= c_cnt_w'(MEM_LAT);
                ST_WAIT: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (w_last_beat && !r_we) begin
                        if (r_gnt == PORT_IF) begin
                            r_if_rdata <= mem_rdata;
                        end else begin
                            r_dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule
`default_nettype wire
